// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type, default width and counter-width derivation
// for the bit-serial adder controller.
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: one-bit full adder built from gate primitives; the only arithmetic in the
// serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic ab_x, ab_a, c_a;
  xor g_x0 (ab_x, a, b);
  xor g_x1 (s, ab_x, ci);
  and g_a0 (ab_a, a, b);
  and g_a1 (c_a, ab_x, ci);
  or  g_o0 (co, ab_a, c_a);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add controller, one bit per clock LSB first through fa_cell.
// Optional subtract mode (sub port, b inverted with carry-in forced to 1) with SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = cnt_width(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_sh_q, sum_sh_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             fa_s, fa_co, ld_carry;
  logic [WIDTH-1:0] ld_b;
`ifdef SERIAL_ADD_SUB_EN
  assign ld_b     = sub ? ~op_b : op_b;
  assign ld_carry = sub | cin;
`else
  assign ld_b     = op_b;
  assign ld_carry = cin;
`endif
  fa_cell u_fa (.a(a_q[0]), .b(b_q[0]), .ci(carry_q), .s(fa_s), .co(fa_co));
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    if (state_q == IDLE && start_valid) begin
      a_d     = op_a;
      b_d     = ld_b;
      carry_d = ld_carry;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      a_d      = a_q >> 1;
      b_d      = b_q >> 1;
      carry_d  = fa_co;
      sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
      cnt_d    = cnt_q + 1'b1;
      // last bit: publish the assembled word and hold the counter at WIDTH-1
      if (cnt_q == CW'(WIDTH - 1)) begin
        sum_d   = sum_sh_d;
        cout_d  = fa_co;
        cnt_d   = cnt_q;
        state_d = DONE;
      end
    end else if (state_q == DONE && res_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end
  assign start_ready = state_q == IDLE;
  assign res_valid   = state_q == DONE;
  assign busy        = state_q != IDLE;
  assign sum         = sum_q;
  assign cout        = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=2;
// subtract cases are included when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start_valid = 1'b0, res_ready = 1'b0, cin = 1'b0;
  logic [7:0] op_a = '0, op_b = '0;
  logic       start_ready, res_valid, cout, busy;
  logic [7:0] sum;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub_r = 1'b0;
`endif
  logic       start_valid2 = 1'b0, res_ready2 = 1'b1, cin2 = 1'b0;
  logic [1:0] op_a2 = '0, op_b2 = '0;
  logic       start_ready2, res_valid2, cout2, busy2;
  logic [1:0] sum2;
  int         n_cmp = 0, n_err = 0, cyc = 0;
  logic [8:0] sb8[$];
  logic [2:0] sb2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub_r),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid2), .start_ready(start_ready2),
    .op_a(op_a2), .op_b(op_b2), .cin(cin2),
`ifdef SERIAL_ADD_SUB_EN
    .sub(1'b0),
`endif
    .res_valid(res_valid2), .res_ready(res_ready2), .sum(sum2), .cout(cout2), .busy(busy2)
  );

  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic s, input string name);
    int k;
    logic [8:0] exp, got;
    k = 0;
    while (!start_ready && k < 30) begin @(posedge clk); #1; k++; end
    n_cmp++;
    if (start_ready !== 1'b1) begin
      n_err++; $display("FAIL %s ready_wait: start_ready=%b required 1", name, start_ready);
    end
    start_valid = 1'b1; op_a = a; op_b = b; cin = c;
`ifdef SERIAL_ADD_SUB_EN
    sub_r = s;
`endif
    exp = s ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b} + {8'd0, c});
    sb8.push_back(exp);
    @(posedge clk); #1;
    start_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 20) begin @(posedge clk); #1; k++; end
    n_cmp++;
    if (k !== 8) begin
      n_err++; $display("FAIL %s latency: got %0d cycles required 8", name, k);
    end
    got = {cout, sum};
    exp = sb8.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL %s result: {cout,sum}=%h required %h", name, got, exp);
    end
  endtask

  task automatic take_result(input string name);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_cmp++;
    if ({start_ready, res_valid, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL %s handoff: {start_ready,res_valid,busy}=%b required 100", name,
               {start_ready, res_valid, busy});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({start_ready, res_valid, busy, cout, sum} !== 12'b100_0_00000000) begin
      n_err++; $display("FAIL reset8: {rdy,vld,busy,cout,sum}=%b required 100000000000",
                        {start_ready, res_valid, busy, cout, sum});
    end
    n_cmp++;
    if ({start_ready2, res_valid2, busy2, cout2, sum2} !== 6'b100_0_00) begin
      n_err++; $display("FAIL reset2: {rdy,vld,busy,cout,sum}=%b required 100000",
                        {start_ready2, res_valid2, busy2, cout2, sum2});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    run_job(8'h35, 8'h4A, 1'b0, 1'b0, "basic");
    take_result("basic");
  endtask

  task automatic test_carry;
    run_job(8'hFF, 8'h01, 1'b0, 1'b0, "ripple1");
    take_result("ripple1");
    run_job(8'hFF, 8'hFF, 1'b1, 1'b0, "ripple2");
    take_result("ripple2");
  endtask

  task automatic test_back_pressure;
    run_job(8'hC3, 8'h3D, 1'b1, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      start_valid = ~start_valid;
      op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if ({start_ready, res_valid, busy, cout, sum} !== {3'b011, 9'h101}) begin
        n_err++; $display("FAIL bp_hold%0d: {rdy,vld,busy,cout,sum}=%b required 011100000001",
                          i, {start_ready, res_valid, busy, cout, sum});
      end
    end
    start_valid = 1'b0;
    take_result("bp");
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, cout, sum} !== 10'b0_1_00000001) begin
      n_err++; $display("FAIL bp_after: {busy,cout,sum}=%b required 0100000001",
                        {busy, cout, sum});
    end
  endtask

  task automatic test_reset_mid_run;
    start_valid = 1'b1; op_a = 8'hAA; op_b = 8'h55; cin = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL midrun_busy: busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({start_ready, res_valid, busy, cout, sum} !== 12'b100_0_00000000) begin
      n_err++; $display("FAIL midrun_reset: {rdy,vld,busy,cout,sum}=%b required 100000000000",
                        {start_ready, res_valid, busy, cout, sum});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(8'h01, 8'h02, 1'b0, 1'b0, "after_reset");
    take_result("after_reset");
  endtask

  task automatic test_sub;
`ifdef SERIAL_ADD_SUB_EN
    run_job(8'h10, 8'h01, 1'b1, 1'b1, "sub1");
    take_result("sub1");
    run_job(8'h00, 8'h01, 1'b0, 1'b1, "sub2");
    take_result("sub2");
    sub_r = 1'b0;
`endif
  endtask

  task automatic test_back_to_back;
    int k, prev;
    logic [2:0] exp, got;
    prev = 0;
    for (int i = 0; i < 32; i++) begin
      start_valid2 = 1'b1;
      op_a2 = 2'(i >> 3); op_b2 = 2'(i >> 1); cin2 = 1'(i);
      sb2.push_back({1'b0, op_a2} + {1'b0, op_b2} + {2'b0, cin2});
      @(posedge clk); #1;
      start_valid2 = 1'b0;
      if (i > 0) begin
        n_cmp++;
        if (cyc - prev !== 4) begin
          n_err++; $display("FAIL b2b_interval%0d: got %0d cycles required 4", i, cyc - prev);
        end
      end
      prev = cyc;
      k = 0;
      while (!res_valid2 && k < 10) begin @(posedge clk); #1; k++; end
      got = {cout2, sum2};
      exp = sb2.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL b2b_result%0d: {cout,sum}=%b required %b", i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_back_pressure;
    test_reset_mid_run;
    test_sub;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that time-shares a single one-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It sits between a requester issuing add jobs over a valid/ready handshake and the gate-level full-adder datapath. It owns operand capture, the carry register, the bit counter and result hand-off.

## Interface
- WIDTH, 8: operand/result width in bits; legal range is WIDTH >= 2.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start_valid  in  1  requester has a job on op_a/op_b/cin (and sub).
- start_ready  out  1  controller can accept a job.
- op_a  in  WIDTH  augend; sampled only on the accept edge.
- op_b  in  WIDTH  addend; sampled only on the accept edge.
- cin  in  1  carry-in; sampled only on the accept edge.
- sub  in  1  subtract request; this port exists only with SERIAL_ADD_SUB_EN.
- res_valid  out  1  sum/cout hold a completed result.
- res_ready  in  1  consumer takes the result.
- sum  out  WIDTH  registered result.
- cout  out  1  registered final carry-out.
- busy  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - start_ready=1.
  - On start_valid&&start_ready: load a_sh<=op_a, b_sh<=op_b, carry<=cin, cnt<=0, then go to RUN.
- **RUN**
  - Each cycle, fa_cell computes the sum bit and the carry from a_sh[0], b_sh[0] and carry.
  - The sum bit shifts into sum_sh at the MSB; a_sh and b_sh shift right; carry takes the cell's carry-out; cnt increments.
  - When cnt==WIDTH-1: transfer sum_sh (including the final bit) to sum and the cell's carry-out to cout, then go to DONE.
- **DONE**
  - res_valid=1. sum and cout are held stable until res_ready=1.
  - On res_valid&&res_ready go to IDLE. res_valid falls on that edge.
- start_ready is 0 in RUN and DONE. start_valid is ignored there, and operand changes are ignored.
- sum/cout keep the last result after hand-off until the next completion overwrites them.
- Arithmetic: {cout,sum} = op_a + op_b + cin, computed modulo 2^(WIDTH+1). Carry out of the MSB goes only to cout.
- cnt is $clog2(WIDTH) bits wide; it never wraps past WIDTH-1.
- Reset, at any time including mid-RUN or DONE:
  - The in-flight job is discarded and the FSM goes to IDLE.
  - No partial result appears on sum/cout.

## Timing
- Reset values: start_ready=1, res_valid=0, busy=0, sum=0, cout=0; all internal registers are 0.
- Accept edge E0. Bits 0..WIDTH-1 are processed on edges E1..E(WIDTH).
- res_valid rises after E(WIDTH), i.e. latency is WIDTH cycles from accept to result.
- With res_ready tied high, the result is taken on E(WIDTH+1) and start_ready returns on that same edge. Back-to-back throughput is therefore one job per WIDTH+2 cycles.
- There is no combinational path from any input to any output. start_ready, res_valid and busy decode directly from the state register.

## Configuration
- Macro: SERIAL_ADD_SUB_EN.
- **With SERIAL_ADD_SUB_EN**
  - The sub port exists.
  - If sub=1 on the accept edge: b_sh<=~op_b, carry<=1, and cin is ignored.
  - The result is op_a-op_b; cout=1 means no borrow.
  - With sub=0, behaviour is identical to the macro-absent build.
- **Without SERIAL_ADD_SUB_EN**
  - The sub port and its logic are absent; the block adds only.

## Structure
- Package serial_add_pkg holds:
  - the state enum (IDLE, RUN, DONE), 2 bits;
  - the default WIDTH constant;
  - the counter-width localparam derivation.
- Sub-module fa_cell: a combinational one-bit full adder built from gate primitives (xor/and/or), instantiated exactly once.
- The controller itself contains only registers, the FSM and muxing.

## Test plan
- All cases use WIDTH=8 unless stated.
- **Basic add:** 0x35+0x4A, cin=0 → sum=0x7F, cout=0, res_valid exactly 8 cycles after accept.
- **Full carry ripple:** 0xFF+0x01, cin=0 → sum=0x00, cout=1. Also 0xFF+0xFF, cin=1 → sum=0xFF, cout=1.
- **Back-pressure:**
  - Hold res_ready=0 for 5 cycles in DONE while toggling start_valid and the operands.
  - Required: sum/cout stay stable, start_ready=0, and no new job is accepted.
  - After res_ready=1, IDLE follows on the next edge.
- **Reset mid-RUN:**
  - Assert rst_n=0 after bit 3 of 0xAA+0x55.
  - Required: all outputs return to their reset values immediately.
  - Then 0x01+0x02 after reset → sum=0x03, cout=0.
- **Subtract (SERIAL_ADD_SUB_EN):** 0x10-0x01 → sum=0x0F, cout=1. 0x00-0x01 → sum=0xFF, cout=0.
- **Exhaustive at WIDTH=2:**
  - Run all 32 combinations of op_a, op_b and cin, issued back-to-back with res_ready=1.
  - Required: each {cout,sum} equals the reference sum, and each job takes exactly 4 cycles from accept to the next accept.
